// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI read-channel arbiter with round-robin priority.
// Exactly one read transaction is in flight at a time: address phase, then data phase.
module axi_rd_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,

  input  logic             M0_ARVALID,
  output logic             M0_ARREADY,
  input  logic [WIDTH-1:0] M0_ARADDR,
  output logic             M0_RVALID,
  input  logic             M0_RREADY,
  output logic [WIDTH-1:0] M0_RDATA,
  output logic [1:0]       M0_RRESP,

  input  logic             M1_ARVALID,
  output logic             M1_ARREADY,
  input  logic [WIDTH-1:0] M1_ARADDR,
  output logic             M1_RVALID,
  input  logic             M1_RREADY,
  output logic [WIDTH-1:0] M1_RDATA,
  output logic [1:0]       M1_RRESP,

  output logic             S_ARVALID,
  input  logic             S_ARREADY,
  output logic [WIDTH-1:0] S_ARADDR,
  input  logic             S_RVALID,
  output logic             S_RREADY,
  input  logic [WIDTH-1:0] S_RDATA,
  input  logic [1:0]       S_RRESP,

  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   rr;
  logic   winner;

  // A lone requester wins outright; only a tie consults the round-robin pointer.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = rr;
    if (M0_ARVALID && !M1_ARVALID) begin
      winner = 1'b0;
    end else if (M1_ARVALID && !M0_ARVALID) begin
      winner = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      rr         <= 1'b0;
      grant      <= 1'b0;
      S_ARVALID  <= 1'b0;
      S_ARADDR   <= '0;
      M0_ARREADY <= 1'b0;
      M1_ARREADY <= 1'b0;
    end else begin
      // ARREADY is a one-cycle pulse; it is re-armed only on a fresh grant.
      M0_ARREADY <= 1'b0;
      M1_ARREADY <= 1'b0;
      case (state)
        IDLE: begin
          if (M0_ARVALID || M1_ARVALID) begin
            grant      <= winner;
            S_ARADDR   <= winner ? M1_ARADDR : M0_ARADDR;
            S_ARVALID  <= 1'b1;
            M0_ARREADY <= !winner;
            M1_ARREADY <= winner;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          // Returning to IDLE here forces at least one idle cycle before the next grant.
          if (S_RVALID && S_RREADY) begin
            rr    <= ~grant;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Read-data path: only the owner sees the slave, and only while in DATA.
  always_comb begin
    M0_RVALID = 1'b0;
    M0_RDATA  = '0;
    M0_RRESP  = 2'b00;
    M1_RVALID = 1'b0;
    M1_RDATA  = '0;
    M1_RRESP  = 2'b00;
    S_RREADY  = 1'b0;
    if (state == DATA) begin
      if (grant) begin
        M1_RVALID = S_RVALID;
        M1_RDATA  = S_RDATA;
        M1_RRESP  = S_RRESP;
        S_RREADY  = M1_RREADY;
      end else begin
        M0_RVALID = S_RVALID;
        M0_RDATA  = S_RDATA;
        M0_RRESP  = S_RRESP;
        S_RREADY  = M0_RREADY;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a transaction-level reference model is checked
// against every DUT output on each falling edge, plus literal checks per scenario.
module tb_axi_rd_arbiter;

  localparam int WIDTH = 32;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             M0_ARVALID = 1'b0;
  logic             M0_ARREADY;
  logic [WIDTH-1:0] M0_ARADDR = '0;
  logic             M0_RVALID;
  logic             M0_RREADY = 1'b0;
  logic [WIDTH-1:0] M0_RDATA;
  logic [1:0]       M0_RRESP;
  logic             M1_ARVALID = 1'b0;
  logic             M1_ARREADY;
  logic [WIDTH-1:0] M1_ARADDR = '0;
  logic             M1_RVALID;
  logic             M1_RREADY = 1'b0;
  logic [WIDTH-1:0] M1_RDATA;
  logic [1:0]       M1_RRESP;
  logic             S_ARVALID;
  logic             S_ARREADY = 1'b0;
  logic [WIDTH-1:0] S_ARADDR;
  logic             S_RVALID = 1'b0;
  logic             S_RREADY;
  logic [WIDTH-1:0] S_RDATA = '0;
  logic [1:0]       S_RRESP = 2'b00;
  logic             busy;
  logic             grant;

  int total = 0;
  int bad   = 0;

  axi_rd_arbiter #(.WIDTH(WIDTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY), .M0_ARADDR(M0_ARADDR),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
    .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY), .M1_ARADDR(M1_ARADDR),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .busy(busy), .grant(grant)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = no transaction, 1 = address offered, 2 = awaiting data.
  int               m_phase = 0;
  int               m_owner = 0;
  int               m_rr = 0;
  int               m_addr_age = 0;
  logic [WIDTH-1:0] m_addr = '0;

  function automatic int pick();
    if (M0_ARVALID && M1_ARVALID) return m_rr;
    return M1_ARVALID ? 1 : 0;
  endfunction

  function automatic bit owner_rready();
    return (m_owner == 1) ? M1_RREADY : M0_RREADY;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_phase    <= 0;
      m_owner    <= 0;
      m_rr       <= 0;
      m_addr_age <= 0;
      m_addr     <= '0;
    end else if (m_phase == 0) begin
      if (M0_ARVALID || M1_ARVALID) begin
        m_owner    <= pick();
        m_addr     <= (pick() == 1) ? M1_ARADDR : M0_ARADDR;
        m_addr_age <= 0;
        m_phase    <= 1;
      end
    end else if (m_phase == 1) begin
      if (S_ARREADY) m_phase <= 2;
      else m_addr_age <= m_addr_age + 1;
    end else begin
      if (S_RVALID && owner_rready()) begin
        m_phase <= 0;
        m_rr    <= 1 - m_owner;
      end
    end
  end

  function automatic bit sees_data(input int m);
    return (m_phase == 2) && (m_owner == m);
  endfunction

  function automatic bit gets_arready(input int m);
    return (m_phase == 1) && (m_addr_age == 0) && (m_owner == m);
  endfunction

  always @(negedge ACLK) begin
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("grant", 32'(grant), 32'(m_owner == 1));
    check("s_arvalid", 32'(S_ARVALID), 32'(m_phase == 1));
    check("s_araddr", S_ARADDR, m_addr);
    check("m0_arready", 32'(M0_ARREADY), 32'(gets_arready(0)));
    check("m1_arready", 32'(M1_ARREADY), 32'(gets_arready(1)));
    check("m0_rvalid", 32'(M0_RVALID), sees_data(0) ? 32'(S_RVALID) : 32'd0);
    check("m0_rdata", M0_RDATA, sees_data(0) ? S_RDATA : 32'd0);
    check("m0_rresp", 32'(M0_RRESP), sees_data(0) ? 32'(S_RRESP) : 32'd0);
    check("m1_rvalid", 32'(M1_RVALID), sees_data(1) ? 32'(S_RVALID) : 32'd0);
    check("m1_rdata", M1_RDATA, sees_data(1) ? S_RDATA : 32'd0);
    check("m1_rresp", 32'(M1_RRESP), sees_data(1) ? 32'(S_RRESP) : 32'd0);
    check("s_rready", 32'(S_RREADY),
          sees_data(0) ? 32'(M0_RREADY) : sees_data(1) ? 32'(M1_RREADY) : 32'd0);
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_arready(output int who, output int cycles);
    who = -1;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      cycles++;
      if (M0_ARREADY || M1_ARREADY) begin
        who = M1_ARREADY ? 1 : 0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL arready_timeout: got no ARREADY, want one within 20 cycles");
  endtask

  // Both masters request together; the slave accepts and answers at once.
  task automatic contend(output int who);
    int c;
    S_ARREADY  = 1'b1;
    M0_ARADDR  = 32'h0000_0100;
    M1_ARADDR  = 32'h0000_0200;
    M0_ARVALID = 1'b1;
    M1_ARVALID = 1'b1;
    wait_arready(who, c);
    M0_ARVALID = 1'b0;
    M1_ARVALID = 1'b0;
    cyc();
    S_RVALID  = 1'b1;
    S_RDATA   = 32'h1111_0000 + 32'(who);
    M0_RREADY = 1'b1;
    M1_RREADY = 1'b1;
    cyc();
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M0_RREADY = 1'b0;
    M1_RREADY = 1'b0;
  endtask

  task automatic simple_read(input int m, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, output int who,
                             output logic [31:0] rdata, output logic [1:0] rresp);
    int c;
    S_ARREADY = 1'b1;
    if (m == 1) begin M1_ARADDR = addr; M1_ARVALID = 1'b1; end
    else        begin M0_ARADDR = addr; M0_ARVALID = 1'b1; end
    wait_arready(who, c);
    M0_ARVALID = 1'b0;
    M1_ARVALID = 1'b0;
    cyc();
    S_RVALID = 1'b1;
    S_RDATA  = data;
    S_RRESP  = resp;
    if (m == 1) M1_RREADY = 1'b1; else M0_RREADY = 1'b1;
    #1;
    rdata = (m == 1) ? M1_RDATA : M0_RDATA;
    rresp = (m == 1) ? M1_RRESP : M0_RRESP;
    cyc();
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    S_RRESP   = 2'b00;
    M0_RREADY = 1'b0;
    M1_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int               w;
    int               c;
    logic [31:0]      d;
    logic [1:0]       r;
    int               exp_order [3] = '{0, 1, 0};

    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_arvalid", 32'(S_ARVALID), 32'd0);
    check("rst_s_araddr", S_ARADDR, 32'd0);
    check("rst_arready", 32'({M1_ARREADY, M0_ARREADY}), 32'd0);
    ARESETn = 1'b1;
    cyc();

    // Three contended rounds alternate owners starting with master 0.
    for (int i = 0; i < 3; i++) begin
      contend(w);
      check("contend_order", 32'(w), 32'(exp_order[i]));
      check("contend_idle_gap", 32'(busy), 32'd0);
    end

    // Single request from master 0.
    S_ARREADY  = 1'b1;
    M0_ARADDR  = 32'h0000_0010;
    M0_ARVALID = 1'b1;
    cyc();
    check("single_arready", 32'(M0_ARREADY), 32'd1);
    check("single_m1_arready", 32'(M1_ARREADY), 32'd0);
    check("single_araddr", S_ARADDR, 32'h0000_0010);
    M0_ARVALID = 1'b0;
    cyc();
    S_RVALID  = 1'b1;
    S_RDATA   = 32'hA5A5_A5A5;
    S_RRESP   = 2'b00;
    M0_RREADY = 1'b1;
    #1;
    check("single_rvalid", 32'(M0_RVALID), 32'd1);
    check("single_rdata", M0_RDATA, 32'hA5A5_A5A5);
    check("single_m1_rdata", M1_RDATA, 32'd0);
    check("single_m1_rvalid", 32'(M1_RVALID), 32'd0);
    cyc();
    check("single_busy_drop", 32'(busy), 32'd0);
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M0_RREADY = 1'b0;

    // Backpressure on both channels for master 1.
    S_ARREADY  = 1'b0;
    M1_ARADDR  = 32'hCAFE_0040;
    M1_ARVALID = 1'b1;
    wait_arready(w, c);
    check("bp_winner", 32'(w), 32'd1);
    M1_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_arvalid_hold", 32'(S_ARVALID), 32'd1);
      check("bp_araddr_hold", S_ARADDR, 32'hCAFE_0040);
      cyc();
    end
    S_ARREADY = 1'b1;
    cyc();
    S_ARREADY = 1'b0;
    check("bp_arvalid_clear", 32'(S_ARVALID), 32'd0);
    S_RVALID  = 1'b1;
    S_RDATA   = 32'h0000_0077;
    M1_RREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_busy", 32'(busy), 32'd1);
      check("bp_stall_rready", 32'(S_RREADY), 32'd0);
      cyc();
    end
    M1_RREADY = 1'b1;
    #1;
    check("bp_release_rready", 32'(S_RREADY), 32'd1);
    cyc();
    check("bp_done", 32'(busy), 32'd0);
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M1_RREADY = 1'b0;

    // Error response to master 1, after master 0 moved the pointer to 1.
    simple_read(0, 32'h0000_0600, 32'h0000_0011, 2'b00, w, d, r);
    check("pre_err_winner", 32'(w), 32'd0);
    simple_read(1, 32'h0000_0700, 32'hBAD0_BAD0, 2'b10, w, d, r);
    check("err_winner", 32'(w), 32'd1);
    check("err_rresp", 32'(r), 32'd2);
    check("err_rdata", d, 32'hBAD0_BAD0);
    contend(w);
    check("err_rr_back_to_0", 32'(w), 32'd0);

    // Reset while master 1 waits for read data.
    S_ARREADY  = 1'b1;
    M1_ARADDR  = 32'h0000_0300;
    M1_ARVALID = 1'b1;
    wait_arready(w, c);
    M1_ARVALID = 1'b0;
    cyc();
    cyc();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    #1;
    ARESETn = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_grant", 32'(grant), 32'd0);
    check("rstmid_s_arvalid", 32'(S_ARVALID), 32'd0);
    check("rstmid_s_araddr", S_ARADDR, 32'd0);
    S_RVALID  = 1'b1;
    S_RDATA   = 32'h0000_1234;
    M1_RREADY = 1'b1;
    #1;
    check("rstmid_m1_rvalid", 32'(M1_RVALID), 32'd0);
    check("rstmid_m1_rdata", M1_RDATA, 32'd0);
    check("rstmid_s_rready", 32'(S_RREADY), 32'd0);
    cyc();
    cyc();
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M1_RREADY = 1'b0;
    ARESETn   = 1'b1;
    cyc();
    contend(w);
    check("rstmid_next_winner", 32'(w), 32'd0);

    // Master 1 arrives while master 0 is in its data phase.
    S_ARREADY  = 1'b1;
    M0_ARADDR  = 32'h0000_0400;
    M0_ARVALID = 1'b1;
    wait_arready(w, c);
    check("late_first", 32'(w), 32'd0);
    M0_ARVALID = 1'b0;
    cyc();
    M1_ARADDR  = 32'h0000_0500;
    M1_ARVALID = 1'b1;
    cyc();
    check("late_wait_busy", 32'(busy), 32'd1);
    check("late_wait_arready", 32'(M1_ARREADY), 32'd0);
    S_RVALID  = 1'b1;
    S_RDATA   = 32'h0000_0055;
    M0_RREADY = 1'b1;
    cyc();
    check("late_exit_idle", 32'(busy), 32'd0);
    check("late_exit_no_grant", 32'(M1_ARREADY), 32'd0);
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M0_RREADY = 1'b0;
    wait_arready(w, c);
    check("late_second", 32'(w), 32'd1);
    check("late_gap_cycles", 32'(c), 32'd1);
    M1_ARVALID = 1'b0;
    cyc();
    S_RVALID  = 1'b1;
    S_RDATA   = 32'h0000_0066;
    M1_RREADY = 1'b1;
    cyc();
    S_RVALID  = 1'b0;
    S_RDATA   = '0;
    M1_RREADY = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
